// File: rtl/acc_op_sequencer.sv
// Command-driven sequencer for the rotating four-operation accumulator.
// Optional feature: define ACC_SEQ_ABORT_EN to add the `abort` input.
module acc_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready and valid are decoded from state only, never from inputs.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_operand,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [1:0]        cmd_op_start,
  input  logic              cmd_op_hold,
  input  logic              cmd_keep,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic [1:0]        op_sel,
`ifdef ACC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               hold_q, hold_d;
  logic [DATA_W-1:0]  alu_res;
  logic               abort_w;

`ifdef ACC_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    alu_res = acc_q;
    case (op_q)
      2'd0:    alu_res = '0 - opnd_q;
      2'd1:    alu_res = opnd_q & acc_q;
      2'd2:    alu_res = '0 - acc_q;
      default: alu_res = acc_q + opnd_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opnd_d = cmd_operand;
          cnt_d  = cmd_steps;
          op_d   = cmd_op_start;
          hold_d = cmd_op_hold;
          if (!cmd_keep) acc_d = '0;
          state_d = (cmd_steps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // An abort skips the step entirely so acc keeps the partial result.
        if (abort_w) begin
          state_d = S_DONE;
        end else begin
          acc_d = alu_res;
          cnt_d = cnt_q - CNT_W'(1);
          if (!hold_q) op_d = op_q + 2'd1;
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hold_q  <= hold_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign res_data  = acc_q;
  assign op_sel    = op_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Self-checking bench for acc_op_sequencer: directed cases plus random commands,
// results checked against a reference model through an expected-value queue.
module tb_acc_op_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int BUDGET = 100;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_operand;
  logic [CNT_W-1:0]  cmd_steps;
  logic [1:0]        cmd_op_start;
  logic              cmd_op_hold;
  logic              cmd_keep;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic [1:0]        op_sel;
  logic [1:0]        dbg_state;
`ifdef ACC_SEQ_ABORT_EN
  logic              abort;
`endif

  int checks;
  int failures;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mdl_acc;

  acc_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_operand  (cmd_operand),
    .cmd_steps    (cmd_steps),
    .cmd_op_start (cmd_op_start),
    .cmd_op_hold  (cmd_op_hold),
    .cmd_keep     (cmd_keep),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .op_sel       (op_sel),
`ifdef ACC_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] model_step(input logic [1:0] op,
      input logic [DATA_W-1:0] acc, input logic [DATA_W-1:0] opnd);
    case (op)
      2'd0:    return 32'd0 - opnd;
      2'd1:    return opnd & acc;
      2'd2:    return 32'd0 - acc;
      default: return acc + opnd;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [DATA_W-1:0] opnd, input int steps,
                          input logic [1:0] op, input logic hold, input logic keep);
    int n;
    logic [1:0] cur_op;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check_val("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid    = 1'b1;
    cmd_operand  = opnd;
    cmd_steps    = CNT_W'(steps);
    cmd_op_start = op;
    cmd_op_hold  = hold;
    cmd_keep     = keep;
    if (!keep) mdl_acc = '0;
    cur_op = op;
    for (int i = 0; i < steps; i++) begin
      mdl_acc = model_step(cur_op, mdl_acc, opnd);
      if (!hold) cur_op = cur_op + 2'd1;
    end
    exp_q.push_back(mdl_acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int n;
    logic [DATA_W-1:0] exp;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_val(tag, res_data, exp);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    check_val({tag, "_res_valid_after"}, 32'(res_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] rot_acc[4];
  logic [1:0]        rot_op[4];
  logic [DATA_W-1:0] held;

  initial begin
    checks = 0; failures = 0; mdl_acc = '0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_operand = '0; cmd_steps = '0;
    cmd_op_start = '0; cmd_op_hold = 1'b0; cmd_keep = 1'b0; res_ready = 1'b0;
`ifdef ACC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    rot_acc[0] = 32'hFFFF_FFFB; rot_acc[1] = 32'h0000_0001;
    rot_acc[2] = 32'hFFFF_FFFF; rot_acc[3] = 32'h0000_0004;
    rot_op[0] = 2'd0; rot_op[1] = 2'd1; rot_op[2] = 2'd2; rot_op[3] = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_op_sel", 32'(op_sel), 32'd0);
    check_val("rst_res_data", res_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Async reset during the 2nd RUN cycle of a 5-step command
    send_cmd(32'h1234_5678, 5, 2'd3, 1'b1, 1'b0);
    check_val("midrun_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_res_valid", 32'(res_valid), 32'd0);
    check_val("arst_res_data", res_data, 32'd0);
    exp_q.delete();
    mdl_acc = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Rotate trace
    send_cmd(32'd5, 4, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("rot_op_sel%0d", k), 32'(op_sel), 32'(rot_op[k]));
      check_val($sformatf("rot_res_valid_run%0d", k), 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      check_val($sformatf("rot_acc%0d", k), res_data, rot_acc[k]);
    end
    @(negedge clk);
    check_val("rot_res_valid_T4", 32'(res_valid), 32'd1);
    get_result("rot_result");

    // Zero steps, keep / clear
    send_cmd(32'd99, 0, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    check_val("zero_keep_valid", 32'(res_valid), 32'd1);
    check_val("zero_keep_data_const", res_data, 32'h0000_0004);
    get_result("zero_keep");
    send_cmd(32'd99, 0, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_val("zero_clr_valid", 32'(res_valid), 32'd1);
    get_result("zero_clr");

    // Hold with op_sel at 3
    send_cmd(32'hFFFF_FFFF, 3, 2'd3, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("hold_op_sel", 32'(op_sel), 32'd3);
    get_result("hold_wrap");
    check_val("hold_wrap_const", mdl_acc, 32'hFFFF_FFFD);

    // Backpressure in DONE with stray commands
    send_cmd(32'd7, 2, 2'd3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    held = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
    for (int k = 0; k < 10; k++) begin
      cmd_valid    = k[0];
      cmd_operand  = $urandom;
      cmd_steps    = CNT_W'($urandom_range(0, 15));
      cmd_op_start = 2'($urandom_range(0, 3));
      cmd_keep     = 1'b0;
      @(negedge clk);
      check_val("bp_res_valid", 32'(res_valid), 32'd1);
      check_val("bp_res_data", res_data, held);
      check_val("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    get_result("bp_result");

    // Random commands
    for (int k = 0; k < 8; k++) begin
      send_cmd($urandom, $urandom_range(0, 15), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      get_result($sformatf("rand%0d", k));
    end

`ifdef ACC_SEQ_ABORT_EN
    send_cmd(32'd5, 15, 2'd3, 1'b1, 1'b0);
    void'(exp_q.pop_back());
    exp_q.push_back(32'h0000_000A);
    mdl_acc = 32'h0000_000A;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_val("abort_res_valid", 32'(res_valid), 32'd1);
    get_result("abort_result");
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
